// File: rtl/clk_div_ctrl.sv
// Runtime clock divider with a valid/ready ratio interface. Ratio changes and
// stops are deferred to output-period boundaries so clk_out never glitches.
module clk_div_ctrl #(
    parameter int I_CLK_FREQ = 100_000_000,
    parameter int O_CLK_FREQ = 10_000_000,
    parameter int DIV_W      = 16
) (
    input  logic             clk_in,
    input  logic             aresetn,
    input  logic             en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    localparam int               DEFAULT_DIV   = I_CLK_FREQ / O_CLK_FREQ;
    localparam logic [DIV_W-1:0] DEFAULT_DIV_W = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV       = DIV_W'(2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    generate
        if (DEFAULT_DIV < 2 || (64'(DEFAULT_DIV) >> DIV_W) != 64'd0) begin : g_bad_default
            $error("clk_div_ctrl: DEFAULT_DIV must be >= 2 and fit in DIV_W bits");
        end
    endgenerate

    logic [1:0]       state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] cur_div_reg, cur_div_next;
    logic [DIV_W-1:0] pend_reg, pend_next;
    logic             pend_valid_reg, pend_valid_next;
    logic             cfg_err_reg, cfg_err_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;

    logic running;
    logic boundary;
    logic accept;
    logic bad_div;
    logic active_next;

    always_comb begin
        running         = (state_reg != ST_IDLE);
        boundary        = running && (cnt_reg == cur_div_reg - 1'b1);
        accept          = cfg_valid && !pend_valid_reg;
        bad_div         = (cfg_div < MIN_DIV);

        state_next      = state_reg;
        cnt_next        = cnt_reg;
        cur_div_next    = cur_div_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        cfg_err_next    = accept && bad_div;

        case (state_reg)
            ST_IDLE: begin
                if (en) state_next = ST_RUN;
            end
            ST_RUN: begin
                // A stop requested in the boundary cycle has nothing left to finish.
                if (!en) state_next = boundary ? ST_IDLE : ST_STOP;
            end
            ST_STOP: begin
                if (en)            state_next = ST_RUN;
                else if (boundary) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (running && !boundary) cnt_next = cnt_reg + 1'b1;
        else                      cnt_next = '0;

        if (accept && !bad_div) begin
            if (state_reg == ST_IDLE) begin
                cur_div_next = cfg_div;
            end else begin
                pend_next       = cfg_div;
                pend_valid_next = 1'b1;
            end
        end

        // Acceptance needs an empty slot, so this never collides with the store above.
        if (boundary && pend_valid_reg) begin
            cur_div_next    = pend_reg;
            pend_valid_next = 1'b0;
        end

        active_next  = (state_next != ST_IDLE);
        clk_out_next = active_next && (cnt_next < (cur_div_next >> 1));
        tick_next    = active_next && (cnt_next == '0);
    end

    always_ff @(posedge clk_in or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            cur_div_reg    <= DEFAULT_DIV_W;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
            clk_out_reg    <= 1'b0;
            tick_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            cur_div_reg    <= cur_div_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            cfg_err_reg    <= cfg_err_next;
            clk_out_reg    <= clk_out_next;
            tick_reg       <= tick_next;
        end
    end

    assign cfg_ready = !pend_valid_reg;
    assign cfg_err   = cfg_err_reg;
    assign cur_div   = cur_div_reg;
    assign clk_out   = clk_out_reg;
    assign tick      = tick_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: default run, deferred ratio change, reject,
// stop/restart at the boundary and asynchronous reset with a pending ratio.
module tb_clk_div_ctrl;

    localparam int DIV_W = 16;

    logic             clk_in = 1'b0;
    logic             aresetn;
    logic             en;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic [DIV_W-1:0] cur_div;
    logic             clk_out;
    logic             tick;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_ctrl #(
        .I_CLK_FREQ(100_000_000),
        .O_CLK_FREQ(10_000_000),
        .DIV_W     (DIV_W)
    ) dut (
        .clk_in   (clk_in),
        .aresetn  (aresetn),
        .en       (en),
        .cfg_div  (cfg_div),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .cur_div  (cur_div),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DIV_W-1:0] obs, input logic [DIV_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks one output cycle of a running divider at counter value c.
    task automatic chk_wave(input string tag, input int c, input int div);
        chk1({tag, "_clk"}, clk_out, (c < div / 2));
        chk1({tag, "_tick"}, tick, (c == 0));
        $display("%s cnt=%0d clk_out=%0b tick=%0b busy=%0b cur_div=%0d",
                 tag, c, clk_out, tick, busy, cur_div);
    endtask

    initial begin
        aresetn   = 1'b0;
        en        = 1'b0;
        cfg_div   = '0;
        cfg_valid = 1'b0;

        // Reset state
        repeat (2) step();
        chk1("rst_clk_out", clk_out, 1'b0);
        chk1("rst_tick", tick, 1'b0);
        chk1("rst_cfg_ready", cfg_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cfg_err", cfg_err, 1'b0);
        chkw("rst_cur_div", cur_div, 16'd10);
        $display("reset: clk_out=%0b tick=%0b cfg_ready=%0b cur_div=%0d", clk_out, tick, cfg_ready, cur_div);
        aresetn = 1'b1;
        step();
        chk1("idle_busy", busy, 1'b0);

        // Default run: first tick one cycle after en is sampled, period 10
        en = 1'b1;
        step();
        chk1("start_busy", busy, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk_wave("run10", i % 10, 10);
            step();
        end

        // Mid-period change to 4 at cnt=3: current period still lasts 10
        repeat (3) step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        step();
        cfg_valid = 1'b0;
        chk1("pend_ready_low", cfg_ready, 1'b0);
        chkw("pend_div_unchanged", cur_div, 16'd10);
        for (int c = 4; c < 10; c++) begin
            chk_wave("tail10", c, 10);
            step();
        end
        chkw("load_div4", cur_div, 16'd4);
        chk1("load_ready", cfg_ready, 1'b1);
        for (int j = 0; j < 8; j++) begin
            chk_wave("run4", j % 4, 4);
            step();
        end

        // Reject: ratio 1 pulses cfg_err once and changes nothing
        cfg_valid = 1'b1;
        cfg_div   = 16'd1;
        step();
        cfg_valid = 1'b0;
        chk1("rej_err", cfg_err, 1'b1);
        chk1("rej_ready", cfg_ready, 1'b1);
        chk_wave("rej4", 1, 4);
        step();
        chk1("rej_err_once", cfg_err, 1'b0);
        chk_wave("rej4", 2, 4);
        repeat (2) step();
        chkw("rej_div", cur_div, 16'd4);
        chk_wave("rej4", 0, 4);

        // Request accepted in the boundary cycle waits for the following boundary
        repeat (3) step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd10;
        step();
        cfg_valid = 1'b0;
        chkw("bnd_div_old", cur_div, 16'd4);
        chk1("bnd_ready_low", cfg_ready, 1'b0);
        chk_wave("bnd4", 0, 4);
        repeat (4) step();
        chkw("bnd_div_new", cur_div, 16'd10);
        chk1("bnd_ready", cfg_ready, 1'b1);
        chk_wave("bnd10", 0, 10);

        // Stop at cnt=2: 7 more running cycles then idle
        repeat (2) step();
        en = 1'b0;
        for (int c = 3; c < 10; c++) begin
            step();
            chk1("stop_busy", busy, 1'b1);
            chk_wave("stop10", c, 10);
        end
        step();
        chk1("stopped_busy", busy, 1'b0);
        chk1("stopped_clk", clk_out, 1'b0);
        chk1("stopped_tick", tick, 1'b0);

        // Second run, en re-asserted in the boundary cycle of STOP: no gap
        en = 1'b1;
        step();
        chk_wave("rerun", 0, 10);
        repeat (2) step();
        en = 1'b0;
        repeat (7) step();
        chk_wave("rerun_bnd", 9, 10);
        en = 1'b1;
        step();
        chk1("nogap_busy", busy, 1'b1);
        chk_wave("nogap", 0, 10);
        step();
        chk_wave("nogap", 1, 10);

        // Async reset at cnt=6 with ratio 5 pending
        repeat (2) step();
        cfg_valid = 1'b1;
        cfg_div   = 16'd5;
        step();
        cfg_valid = 1'b0;
        chk1("pend5_ready", cfg_ready, 1'b0);
        repeat (2) step();
        chk_wave("pre_rst", 6, 10);
        aresetn = 1'b0;
        #2;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_ready", cfg_ready, 1'b1);
        chk1("arst_clk", clk_out, 1'b0);
        chk1("arst_tick", tick, 1'b0);
        chkw("arst_div", cur_div, 16'd10);
        $display("async reset: busy=%0b cfg_ready=%0b cur_div=%0d", busy, cfg_ready, cur_div);
        en = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        chkw("post_rst_div", cur_div, 16'd10);
        en = 1'b1;
        step();
        for (int c = 0; c < 7; c++) begin
            chk_wave("post_rst", c, 10);
            step();
        end
        chkw("post_rst_div_kept", cur_div, 16'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime controller for the DAQ clock-division path. It produces a divided clock and a one-cycle tick from `clk_in`, and lets software or a sequencer change the division ratio through a valid/ready handshake. Ratio changes and stops take effect only at output-period boundaries, so `clk_out` never carries a runt pulse. It sits between the configuration logic and the downstream logic that consumes the divided clock/tick, such as the trigger and sampling timers.

## Interface
Parameters:
- `I_CLK_FREQ`, 100_000_000: input clock frequency in Hz.
- `O_CLK_FREQ`, 10_000_000: reset-default output frequency in Hz. `DEFAULT_DIV = I_CLK_FREQ / O_CLK_FREQ`.
- `DIV_W`, 16: width of the division ratio.
- Elaboration check: `DEFAULT_DIV` must be ≥2 and fit in `DIV_W` bits.

Ports:
- `clk_in` in 1: single clock domain.
- `aresetn` in 1: reset, asynchronous and active-low.
- `en` in 1: run enable, level-sensitive.
- `cfg_div` in DIV_W: requested output period, counted in `clk_in` cycles.
- `cfg_valid` in 1: a configuration request is present.
- `cfg_ready` out 1: the controller can accept a request.
- `cfg_err` out 1: one-cycle pulse when a request was rejected.
- `cur_div` out DIV_W: active division ratio.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: one-cycle pulse in the first cycle of each output period.
- `busy` out 1: high while the output is running or a stop is in progress.

## Operation
- State machine has three states: IDLE, RUN and STOP.
  - IDLE → RUN when `en`=1.
  - RUN → STOP when `en`=0.
  - STOP → RUN when `en`=1 again, with no gap and the current period continuing.
  - STOP → IDLE at the period boundary.
- Period counter `cnt`:
  - Counts 0..`cur_div`-1, then wraps.
  - The boundary is the cycle where `cnt`=`cur_div`-1 and the state is RUN or STOP.
- Output waveform:
  - `clk_out`=1 when `cnt` < `cur_div`>>1; otherwise 0.
  - Odd ratios give a shorter high phase (div 5: 2 cycles high, 3 low).
- `tick`=1 exactly in cycles where `cnt`=0 while running.
- In IDLE: `clk_out`=0, `tick`=0, `cnt` held at 0.
- Config handshake: a request is accepted when `cfg_valid` && `cfg_ready`.
  - `cfg_div` < 2: the request is rejected, `cfg_err` pulses the next cycle, and nothing else changes.
  - Accepted in IDLE: `cur_div` is updated on the next cycle.
  - Accepted in RUN or STOP: the value is stored as pending and `cfg_ready` drops.
  - At the next boundary, the pending value loads into `cur_div` in the same cycle that `cnt` returns to 0. `cfg_ready` returns to 1 on that same cycle.
  - A request accepted in the boundary cycle itself is applied at the following boundary, not the current one.
- Pending depth is 1. `cfg_ready`=0 only while a value is pending.
- `busy`=1 in RUN and STOP.

## Timing
- Reset values (all asserted asynchronously):
  - `clk_out`=0, `tick`=0, `cfg_err`=0, `busy`=0, `cfg_ready`=1.
  - `cur_div`=`DEFAULT_DIV`, state IDLE, `cnt`=0, pending cleared.
- Reset mid-operation:
  - Outputs go to their reset values immediately, with no completion of the current period.
  - Any pending ratio is discarded.
- Start latency: `en` sampled high in IDLE at edge N → `clk_out`=1 and `tick`=1 in cycle N+1, with `cnt`=0.
- Stop:
  - `en` sampled low in RUN → the current period completes in full.
  - The cycle after the boundary is IDLE, with `clk_out`=0 and `busy`=0.
  - If `en` returns high at the boundary cycle while in STOP, the next period starts without a gap.
- Config latency:
  - IDLE: 1 cycle from acceptance to the `cur_div` update.
  - RUN: from 1 cycle up to `cur_div` cycles.
- `cfg_err` is asserted for exactly 1 cycle per rejected request.
- Rejected requests never lower `cfg_ready`.
- Counter comparisons are unsigned, `DIV_W` bits wide. `cnt` never exceeds `cur_div`-1.

## Test plan
- Reset check: with `aresetn` low, `clk_out`=0, `tick`=0, `cfg_ready`=1 and `cur_div`=10 (default parameters).
- Default run: `en`=1 → `clk_out` is 5 cycles high and 5 low, `tick` occurs every 10 cycles, and the first tick is 1 cycle after `en` is sampled.
- Mid-period change: in RUN at `cnt`=3, send `cfg_div`=4. Required response:
  - `cfg_ready` drops.
  - The current period completes at 10 cycles.
  - Subsequent periods are 4 cycles (2 high, 2 low).
  - `cur_div`=4 and `cfg_ready`=1 at the boundary.
- Reject path: `cfg_div`=1 → `cfg_err` is a single-cycle pulse, `cur_div` is unchanged and the waveform is unaffected.
- Stop: `en`=0 at `cnt`=2 with div 10 → 7 more running cycles, then IDLE with `clk_out`=0 and `busy`=0. A second run re-asserting `en` at the boundary cycle must produce no gap.
- Async reset at `cnt`=6 with a pending ratio of 5 → immediate reset values, and after release `cur_div`=10.
